// File: rtl/cmd_frame_rx_pkg.sv
// Shared definitions for the serial command frame receiver.
// Frame layout, mode encodings and checksum helper.
package cmd_frame_rx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam int FRM_IDX_SYNC = 0;
    localparam int FRM_IDX_CMD  = 1;
    localparam int FRM_IDX_MODE = 2;
    localparam int FRM_IDX_CSUM = 3;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_HYBRID = 2'd1,
        MODE_MANUAL = 2'd2,
        MODE_SLEEP  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [3:0] speed;
        logic [3:0] dir;
    } cmd_t;

    function automatic logic [7:0] frame_csum(
        input logic [7:0] cmd_b,
        input logic [7:0] mode_b,
        input logic [7:0] sync_b
    );
        return cmd_b ^ mode_b ^ sync_b;
    endfunction

endpackage

// File: rtl/cmd_frame_rx_uart_rx_byte.sv
// 8N1 UART byte receiver with 2-FF input synchroniser.
// Emits one-cycle byte_valid / byte_err pulses at mid stop bit.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;

    // Bring rx into the clock domain and keep one older sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Byte FSM: find start edge, confirm at mid-bit, shift 8 bits LSB first, check stop
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        data    <= {rx_sync, data[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt        <= '0;
                        byte_valid <= rx_sync;
                        byte_err   <= !rx_sync;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_frame_rx.sv
// Command frame receiver: SYNC, {speed,dir}, mode, checksum.
// Holds last good command, flags frame errors and link loss.
module cmd_frame_rx
    import cmd_frame_rx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter logic [3:0] DEF_SPEED    = 4'd5,
    parameter logic [3:0] DEF_DIR      = 4'd8,
    parameter int         BYTE_GAP     = 2 * 10 * CLKS_PER_BIT,
    parameter int         LINK_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] speed_cmd,
    output logic [3:0] dir_cmd,
    output logic [1:0] mode,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       link_lost
);

    localparam logic [1:0] WAIT_SYNC = 2'(FRM_IDX_SYNC);
    localparam logic [1:0] GET_CMD   = 2'(FRM_IDX_CMD);
    localparam logic [1:0] GET_MODE  = 2'(FRM_IDX_MODE);
    localparam logic [1:0] GET_CSUM  = 2'(FRM_IDX_CSUM);

    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam int LW = $clog2(LINK_TIMEOUT + 1);

    logic [7:0]    rx_data;
    logic          byte_valid;
    logic          byte_err;

    logic [1:0]    state;
    cmd_t          cmd_byte;
    logic [7:0]    mode_byte;
    logic [GW-1:0] gap_cnt;
    logic [LW-1:0] link_cnt;

    logic          in_get;
    logic          gap_to;
    logic          mode_bad;
    logic          csum_bad;
    logic          brk_err;
    logic          err;
    logic          good;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (rx_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    // Error and completion qualification; any error suppresses the byte event
    always_comb begin
        in_get   = (state != WAIT_SYNC);
        gap_to   = in_get && (gap_cnt == GW'(BYTE_GAP));
        mode_bad = byte_valid && (state == GET_MODE)
                   && (rx_data[7:2] != 6'd0);
        csum_bad = byte_valid && (state == GET_CSUM)
                   && (rx_data != frame_csum(cmd_byte, mode_byte, SYNC_BYTE));
        brk_err  = byte_err && in_get;
        err      = gap_to || mode_bad || csum_bad || brk_err;
        good     = byte_valid && (state == GET_CSUM) && !err;
    end

    // Inter-byte gap counter, live only while a frame is in progress
    always_ff @(posedge clk) begin
        if (rst || !in_get || byte_valid || err) begin
            gap_cnt <= '0;
        end else if (gap_cnt != GW'(BYTE_GAP)) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Frame FSM: hunt for SYNC, then collect cmd, mode and checksum bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_SYNC;
            cmd_byte  <= '0;
            mode_byte <= '0;
        end else if (err) begin
            state <= WAIT_SYNC;
        end else if (byte_valid) begin
            unique case (state)
                WAIT_SYNC: begin
                    if (rx_data == SYNC_BYTE) begin
                        state <= GET_CMD;
                    end
                end
                GET_CMD: begin
                    cmd_byte <= rx_data;
                    state    <= GET_MODE;
                end
                GET_MODE: begin
                    mode_byte <= rx_data;
                    state     <= GET_CSUM;
                end
                GET_CSUM: state <= WAIT_SYNC;
                default:  state <= WAIT_SYNC;
            endcase
        end
    end

    // Command outputs move only on a good frame; status pulses are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_cmd <= DEF_SPEED;
            dir_cmd   <= DEF_DIR;
            mode      <= MODE_SLEEP;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cmd_valid <= good;
            frame_err <= err;
            if (good) begin
                speed_cmd <= cmd_byte.speed;
                dir_cmd   <= cmd_byte.dir;
                mode      <= mode_byte[1:0];
            end
        end
    end

    // Saturating link timer; a good frame wins over a same-cycle timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            link_cnt  <= '0;
            link_lost <= 1'b1;
        end else if (good) begin
            link_cnt  <= '0;
            link_lost <= 1'b0;
        end else begin
            if (link_cnt != LW'(LINK_TIMEOUT)) begin
                link_cnt <= link_cnt + 1'b1;
            end
            if (link_cnt >= LW'(LINK_TIMEOUT - 1)) begin
                link_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed bench for cmd_frame_rx at 4 clocks per bit.
// Drives UART bytes and checks outputs, pulses and link timing.
module tb_cmd_frame_rx;

    localparam int CPB = 4;
    localparam int LTO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [3:0] speed_cmd;
    logic [3:0] dir_cmd;
    logic [1:0] mode;
    logic       cmd_valid;
    logic       frame_err;
    logic       link_lost;

    int n_chk = 0;
    int n_err = 0;

    int cyc = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int valid_cyc = 0;
    int rise_cyc = 0;
    logic lost_at_valid = 1'b1;
    logic prev_lost = 1'b1;

    int cv0;
    int fe0;

    cmd_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .LINK_TIMEOUT(LTO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .speed_cmd(speed_cmd),
        .dir_cmd  (dir_cmd),
        .mode     (mode),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err),
        .link_lost(link_lost)
    );

    always #5 clk = ~clk;

    // Observe pulses and link_lost edges away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cmd_valid) begin
            cv_cnt = cv_cnt + 1;
            valid_cyc = cyc;
            lost_at_valid = link_lost;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (link_lost && !prev_lost) rise_cyc = cyc;
        prev_lost = link_lost;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
        drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic mark;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_speed", speed_cmd, 4'h5);
        chk("rst_dir", dir_cmd, 4'h8);
        chk("rst_mode", mode, 2'd3);
        chk("rst_lost", link_lost, 1'b1);
        chk("rst_cv", cv_cnt, 0);
        chk("rst_fe", fe_cnt, 0);

        // good frame, with a short rx glitch between SYNC and CMD
        mark();
        send_byte(8'hA5, 1'b1);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h98, 1'b1);
        repeat (10) @(negedge clk);
        chk("g1_cv", cv_cnt - cv0, 1);
        chk("g1_fe", fe_cnt - fe0, 0);
        chk("g1_speed", speed_cmd, 4'h3);
        chk("g1_dir", dir_cmd, 4'hC);
        chk("g1_mode", mode, 2'd1);
        chk("g1_lost_at_valid", lost_at_valid, 1'b0);

        // link timeout measured from the cmd_valid cycle
        repeat (60) @(negedge clk);
        chk("lto_delay", rise_cyc - valid_cyc, LTO);
        chk("lto_lost", link_lost, 1'b1);
        chk("lto_hold_speed", speed_cmd, 4'h3);

        // bad checksum
        mark();
        send_frame(8'hA5, 8'h3C, 8'h01, 8'h99);
        chk("csum_fe", fe_cnt - fe0, 1);
        chk("csum_cv", cv_cnt - cv0, 0);
        chk("csum_speed", speed_cmd, 4'h3);
        chk("csum_dir", dir_cmd, 4'hC);
        chk("csum_mode", mode, 2'd1);

        // garbage then good frame
        mark();
        send_byte(8'h00, 1'b1);
        send_byte(8'h7F, 1'b1);
        send_frame(8'hA5, 8'hF0, 8'h02, 8'h57);
        chk("garb_fe", fe_cnt - fe0, 0);
        chk("garb_cv", cv_cnt - cv0, 1);
        chk("garb_speed", speed_cmd, 4'hF);
        chk("garb_dir", dir_cmd, 4'h0);
        chk("garb_mode", mode, 2'd2);

        // stop bit error on mode byte, then recovery
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h01, 1'b0);
        repeat (6) @(negedge clk);
        chk("stop_fe", fe_cnt - fe0, 1);
        chk("stop_hold_speed", speed_cmd, 4'hF);
        send_frame(8'hA5, 8'h12, 8'h00, 8'hB7);
        chk("stop_rec_cv", cv_cnt - cv0, 1);
        chk("stop_rec_speed", speed_cmd, 4'h1);
        chk("stop_rec_dir", dir_cmd, 4'h2);
        chk("stop_rec_mode", mode, 2'd0);

        // reserved mode bits set, then recovery
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h05, 1'b1);
        repeat (6) @(negedge clk);
        chk("mbad_fe", fe_cnt - fe0, 1);
        chk("mbad_hold_mode", mode, 2'd0);
        send_frame(8'hA5, 8'h47, 8'h03, 8'hE1);
        chk("mbad_rec_cv", cv_cnt - cv0, 1);
        chk("mbad_rec_speed", speed_cmd, 4'h4);
        chk("mbad_rec_dir", dir_cmd, 4'h7);
        chk("mbad_rec_mode", mode, 2'd3);

        // inter-byte gap expiry
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (200) @(negedge clk);
        chk("gap_fe", fe_cnt - fe0, 1);
        chk("gap_cv", cv_cnt - cv0, 0);
        chk("gap_hold_dir", dir_cmd, 4'h7);

        // reset in the middle of a frame and of a byte
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mrst_speed", speed_cmd, 4'h5);
        chk("mrst_dir", dir_cmd, 4'h8);
        chk("mrst_mode", mode, 2'd3);
        chk("mrst_lost", link_lost, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h98, 1'b1);
        repeat (10) @(negedge clk);
        chk("mrst_fe", fe_cnt - fe0, 0);
        chk("mrst_cv", cv_cnt - cv0, 0);
        chk("mrst_hold_speed", speed_cmd, 4'h5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
